jb_nco_mixer: RTL and testbench

- Complex digital mixer that sits directly downstream of the NCO.
- Consumes the NCO's registered {Q,I} = {sin,cos} word and multiplies it with a streaming IQ sample, giving out = din × (cos + j·sin).
- Contains a data-path alignment delay that matches NCO latency, a 3-stage pipelined complex multiplier, round-half-up, saturation, and sticky saturation status.
- Output feeds the DUC/DDC filter chain.

---
 rtl/jb_nco_mixer.sv | 171 +++++++++++++++++
 tb/tb_jb_nco_mixer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jb_nco_mixer.sv
// jb_nco_mixer: complex mixer downstream of the NCO.
// out = din * (cos + j*sin), with an alignment delay matched to NCO latency,
// a 3-stage multiplier pipeline, round-half-up, saturation and sticky status.
module jb_nco_mixer #(
  parameter int DATA_WIDTH    = 16,
  parameter int PRECISION     = 16,
  parameter int ALIGN_DELAY   = 7,
  parameter int SAT_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       enable,
  input  logic                       bypass,
  input  logic                       din_valid,
  input  logic [2*DATA_WIDTH-1:0]    din,
  input  logic [2*PRECISION-1:0]     nco_sincos,
  input  logic                       clr_sat,
  output logic                       dout_valid,
  output logic [2*DATA_WIDTH-1:0]    dout,
  output logic                       sat_flag,
  output logic [SAT_CNT_WIDTH-1:0]   sat_count
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = PRECISION;
  localparam int MW = DW + PW;      // product width
  localparam int SW = MW + 1;       // sum width, cannot overflow

  localparam logic signed [SW-1:0] RND  = SW'(1) <<< (PW - 2);
  localparam logic signed [SW-1:0] MAXV = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]        OUT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]        OUT_MIN = {1'b1, {(DW-1){1'b0}}};

  // aligned sample presented to S1
  logic            a_vld;
  logic [2*DW-1:0] a_din;

  generate
    if (ALIGN_DELAY == 0) begin : g_no_align
      assign a_vld = din_valid;
      assign a_din = din;
    end else begin : g_align
      logic [ALIGN_DELAY-1:0] vld_q;
      logic [2*DW-1:0]        dat_q [ALIGN_DELAY];

      // delay line on {din_valid, din}; valid bits drop whenever enable is low
      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          vld_q <= '0;
          for (int k = 0; k < ALIGN_DELAY; k++) dat_q[k] <= '0;
        end else begin
          vld_q[0] <= din_valid & enable;
          dat_q[0] <= din;
          for (int k = 1; k < ALIGN_DELAY; k++) begin
            vld_q[k] <= vld_q[k-1] & enable;
            dat_q[k] <= dat_q[k-1];
          end
        end
      end

      assign a_vld = vld_q[ALIGN_DELAY-1];
      assign a_din = dat_q[ALIGN_DELAY-1];
    end
  endgenerate

  logic signed [DW-1:0] in_i, in_q;
  logic signed [PW-1:0] nco_c, nco_s;

  assign in_i  = a_din[DW-1:0];
  assign in_q  = a_din[2*DW-1:DW];
  assign nco_c = nco_sincos[PW-1:0];
  assign nco_s = nco_sincos[2*PW-1:PW];

  // S1 registers
  logic                 s1_vld, s1_byp;
  logic [2*DW-1:0]      s1_raw;
  logic signed [MW-1:0] s1_ic, s1_qs, s1_is, s1_qc;

  // S1: four partial products; bypass is latched per sample here
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_vld <= 1'b0;
      s1_byp <= 1'b0;
      s1_raw <= '0;
      s1_ic  <= '0;
      s1_qs  <= '0;
      s1_is  <= '0;
      s1_qc  <= '0;
    end else begin
      s1_vld <= a_vld & enable;
      s1_byp <= bypass;
      s1_raw <= a_din;
      s1_ic  <= MW'(in_i) * MW'(nco_c);
      s1_qs  <= MW'(in_q) * MW'(nco_s);
      s1_is  <= MW'(in_i) * MW'(nco_s);
      s1_qc  <= MW'(in_q) * MW'(nco_c);
    end
  end

  // S2 registers
  logic                 s2_vld, s2_byp;
  logic [2*DW-1:0]      s2_raw;
  logic signed [SW-1:0] s2_sum_i, s2_sum_q;

  // S2: complex sums at full width
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s2_vld   <= 1'b0;
      s2_byp   <= 1'b0;
      s2_raw   <= '0;
      s2_sum_i <= '0;
      s2_sum_q <= '0;
    end else begin
      s2_vld   <= s1_vld & enable;
      s2_byp   <= s1_byp;
      s2_raw   <= s1_raw;
      s2_sum_i <= SW'(s1_ic) - SW'(s1_qs);
      s2_sum_q <= SW'(s1_is) + SW'(s1_qc);
    end
  end

  logic signed [SW-1:0] sh_i, sh_q;
  logic [DW-1:0]        res_i, res_q;
  logic                 clip_i, clip_q;
  logic                 s3_fire, sat_evt;

  // round half up, then clamp to the output range
  always_comb begin
    sh_i   = (s2_sum_i + RND) >>> (PW - 1);
    sh_q   = (s2_sum_q + RND) >>> (PW - 1);
    clip_i = (sh_i > MAXV) || (sh_i < MINV);
    clip_q = (sh_q > MAXV) || (sh_q < MINV);
    if (sh_i > MAXV)      res_i = OUT_MAX;
    else if (sh_i < MINV) res_i = OUT_MIN;
    else                  res_i = sh_i[DW-1:0];
    if (sh_q > MAXV)      res_q = OUT_MAX;
    else if (sh_q < MINV) res_q = OUT_MIN;
    else                  res_q = sh_q[DW-1:0];
  end

  assign s3_fire = s2_vld & enable;
  assign sat_evt = s3_fire & ~s2_byp & (clip_i | clip_q);

  // S3: output register, loads only on a valid sample
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_valid <= 1'b0;
      dout       <= '0;
    end else begin
      dout_valid <= s3_fire;
      if (s3_fire) dout <= s2_byp ? s2_raw : {res_q, res_i};
    end
  end

  // sticky saturation status; a new event wins over a same-cycle clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sat_flag  <= 1'b0;
      sat_count <= '0;
    end else if (sat_evt) begin
      sat_flag <= 1'b1;
      if (clr_sat)               sat_count <= SAT_CNT_WIDTH'(1);
      else if (sat_count != '1)  sat_count <= sat_count + 1'b1;
    end else if (clr_sat) begin
      sat_flag  <= 1'b0;
      sat_count <= '0;
    end
  end

endmodule

// File: tb/tb_jb_nco_mixer.sv
// Testbench for jb_nco_mixer: per-cycle comparison against a sample-level model.
module tb_jb_nco_mixer;

  localparam int D   = 7;
  localparam int HN  = 4096;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable, bypass, din_valid, clr_sat;
  logic [31:0] din, nco_sincos;
  logic        dout_valid, sat_flag;
  logic [31:0] dout;
  logic [15:0] sat_count;

  jb_nco_mixer #(
    .DATA_WIDTH(16), .PRECISION(16), .ALIGN_DELAY(D), .SAT_CNT_WIDTH(16)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .bypass(bypass),
    .din_valid(din_valid), .din(din), .nco_sincos(nco_sincos), .clr_sat(clr_sat),
    .dout_valid(dout_valid), .dout(dout), .sat_flag(sat_flag), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // input history, one entry per rising edge
  logic [31:0] din_h [HN];
  logic [31:0] nco_h [HN];
  bit          vld_h [HN];
  bit          byp_h [HN];
  bit          en_h  [HN];
  bit          clr_h [HN];
  int          cyc = 0;

  // expected outputs
  bit          m_dv;
  logic [31:0] m_dout;
  bit          m_flag;
  logic [15:0] m_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint clamp16(input longint v, output bit clipped);
    clipped = (v > 32767) || (v < -32768);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // mathematical mix of one sample: round half up of (x*32768-scaled)/32768, clamp
  function automatic logic [31:0] mix(input logic [31:0] d, input logic [31:0] n,
                                      input bit byp, output bit clipped);
    longint di, dq, nc, ns, si, sq, ri, rq;
    bit ci, cq;
    logic [15:0] oi, oq;
    if (byp) begin
      clipped = 1'b0;
      return d;
    end
    di = longint'($signed(d[15:0]));
    dq = longint'($signed(d[31:16]));
    nc = longint'($signed(n[15:0]));
    ns = longint'($signed(n[31:16]));
    si = di * nc - dq * ns;
    sq = di * ns + dq * nc;
    ri = clamp16((si + 16384) >>> 15, ci);
    rq = clamp16((sq + 16384) >>> 15, cq);
    clipped = ci | cq;
    oi = ri[15:0];
    oq = rq[15:0];
    return {oq, oi};
  endfunction

  // model of what becomes visible after edge c
  task automatic model_edge(input int c);
    int s;
    bit alive, cl, evt;
    s = c - (D + 2);
    alive = 1'b0;
    evt = 1'b0;
    if (s >= 0 && vld_h[s]) begin
      alive = 1'b1;
      for (int k = s; k <= c; k++) if (!en_h[k]) alive = 1'b0;
    end
    if (alive) begin
      m_dout = mix(din_h[s], nco_h[s + D], byp_h[s + D], cl);
      m_dv   = 1'b1;
      evt    = cl;
    end else begin
      m_dv = 1'b0;
    end
    if (evt) begin
      m_flag = 1'b1;
      if (clr_h[c])              m_cnt = 16'd1;
      else if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (clr_h[c]) begin
      m_flag = 1'b0;
      m_cnt  = 16'd0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    din_h[cyc] = din;
    nco_h[cyc] = nco_sincos;
    byp_h[cyc] = bypass;
    en_h[cyc]  = enable;
    clr_h[cyc] = clr_sat;
    vld_h[cyc] = din_valid && resetn;
    if (resetn) model_edge(cyc);
    cyc++;
    @(negedge clk);
    check_eq("dout_valid", 64'(dout_valid), 64'(m_dv));
    check_eq("dout", 64'(dout), 64'(m_dout));
    check_eq("sat_flag", 64'(sat_flag), 64'(m_flag));
    check_eq("sat_count", 64'(sat_count), 64'(m_cnt));
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input logic [31:0] n,
                       input bit b, input bit c);
    din_valid  = v;
    din        = d;
    nco_sincos = n;
    bypass     = b;
    clr_sat    = c;
    step();
  endtask

  task automatic idle(input int n_cyc, input logic [31:0] n);
    for (int k = 0; k < n_cyc; k++) drive(1'b0, 32'h0, n, 1'b0, 1'b0);
  endtask

  function automatic logic [15:0] rnd_nco();
    int v;
    v = int'($urandom_range(65534)) - 32767;
    return v[15:0];
  endfunction

  localparam logic [31:0] NCO_ID  = {16'sd0, 16'sd32767};
  localparam logic [31:0] NCO_90  = {16'sd32767, 16'sd0};
  localparam logic [31:0] NCO_45  = {16'sd32767, 16'sd32767};
  localparam logic [31:0] SAT_IN  = {16'h8000, 16'h8000};

  initial begin
    resetn = 1'b0; enable = 1'b1; bypass = 1'b0; din_valid = 1'b0; clr_sat = 1'b0;
    din = '0; nco_sincos = NCO_ID;
    m_dv = 1'b0; m_dout = '0; m_flag = 1'b0; m_cnt = '0;
    for (int k = 0; k < HN; k++) vld_h[k] = 1'b0;

    // reset state
    idle(3, NCO_ID);
    #2 resetn = 1'b1;
    idle(2, NCO_ID);

    // identity rotation
    drive(1'b1, {16'hFE0C, 16'd1000}, NCO_ID, 1'b0, 1'b0);
    idle(8, NCO_ID);
    check_eq("ident_dv_early", 64'(dout_valid), 64'd0);
    idle(1, NCO_ID);
    check_eq("ident_dv", 64'(dout_valid), 64'd1);
    check_eq("ident_dout", 64'(dout), 64'({16'hFE0C, 16'd1000}));
    check_eq("ident_flag", 64'(sat_flag), 64'd0);
    idle(2, NCO_ID);

    // quarter rotation
    drive(1'b1, {16'd0, 16'd1000}, NCO_90, 1'b0, 1'b0);
    idle(9, NCO_90);
    check_eq("quarter_dout", 64'(dout), 64'({16'd1000, 16'd0}));
    idle(2, NCO_90);

    // saturation, then a second event coinciding with clr_sat
    drive(1'b1, SAT_IN, NCO_45, 1'b0, 1'b0);
    idle(9, NCO_45);
    check_eq("sat_dout", 64'(dout), 64'({16'h8000, 16'h0000}));
    check_eq("sat_flag1", 64'(sat_flag), 64'd1);
    check_eq("sat_cnt1", 64'(sat_count), 64'd1);
    drive(1'b1, SAT_IN, NCO_45, 1'b0, 1'b0);
    idle(8, NCO_45);
    drive(1'b0, 32'h0, NCO_45, 1'b0, 1'b1);
    check_eq("sat_clr_evt_flag", 64'(sat_flag), 64'd1);
    check_eq("sat_clr_evt_cnt", 64'(sat_count), 64'd1);
    drive(1'b1, SAT_IN, NCO_45, 1'b0, 1'b0);
    idle(9, NCO_45);
    check_eq("sat_cnt2", 64'(sat_count), 64'd2);
    drive(1'b0, 32'h0, NCO_45, 1'b0, 1'b1);
    check_eq("clr_flag", 64'(sat_flag), 64'd0);
    check_eq("clr_cnt", 64'(sat_count), 64'd0);

    // streaming with random data/nco, bypass toggling every 7 samples
    for (int k = 0; k < 100; k++)
      drive(1'b1, $urandom(), {rnd_nco(), rnd_nco()}, ((k / 7) % 2) == 1, 1'b0);
    idle(12, NCO_ID);

    // valid gaps and an enable-low window while samples are in flight
    drive(1'b1, $urandom(), NCO_45, 1'b0, 1'b0);
    drive(1'b0, $urandom(), NCO_45, 1'b0, 1'b0);
    drive(1'b1, $urandom(), NCO_45, 1'b0, 1'b0);
    drive(1'b1, $urandom(), NCO_45, 1'b0, 1'b0);
    idle(3, NCO_45);
    enable = 1'b0;
    idle(3, NCO_45);
    enable = 1'b1;
    idle(12, NCO_45);
    drive(1'b1, $urandom(), NCO_45, 1'b0, 1'b0);
    drive(1'b1, $urandom(), NCO_45, 1'b1, 1'b0);
    idle(12, NCO_45);

    // random mix of valid, bypass, enable and clr_sat
    for (int k = 0; k < 60; k++) begin
      enable = ($urandom_range(7) != 0);
      drive($urandom_range(1), $urandom(), {rnd_nco(), rnd_nco()},
            $urandom_range(1), ($urandom_range(9) == 0));
    end
    enable = 1'b1;
    idle(12, NCO_ID);

    // asynchronous reset with five samples in flight
    for (int k = 0; k < 5; k++) drive(1'b1, $urandom(), NCO_45, 1'b0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check_eq("arst_dout", 64'(dout), 64'd0);
    check_eq("arst_dv", 64'(dout_valid), 64'd0);
    check_eq("arst_flag", 64'(sat_flag), 64'd0);
    check_eq("arst_cnt", 64'(sat_count), 64'd0);
    m_dv = 1'b0; m_dout = '0; m_flag = 1'b0; m_cnt = '0;
    for (int k = 0; k < cyc; k++) vld_h[k] = 1'b0;
    idle(2, NCO_ID);
    #2 resetn = 1'b1;
    idle(12, NCO_ID);
    drive(1'b1, {16'd300, 16'hFF38}, NCO_ID, 1'b0, 1'b0);
    idle(9, NCO_ID);
    check_eq("post_rst_dout", 64'(dout), 64'({16'd300, 16'hFF38}));
    idle(3, NCO_ID);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
